pipelined_approx_multiplier: RTL
================================

# pipelined_approx_multiplier

Parametrised, pipelined unsigned WIDTH×WIDTH Wallace-tree multiplier with a runtime approximation mode. The mode zeroes the k least-significant partial-product columns and adds a rounding constant. It is the streaming successor to the combinational 8-bit Wallace tree multiplier: a valid/ready handshake, a configurable pipeline depth and an in-order sideband tag let benches and accelerator datapaths push one operand pair per cycle and compare exact against approximate products.

## Interface
- WIDTH, 8: operand width in bits; legal values 4..32.
- STAGES, 3: pipeline register stages from accept to output; legal values 1..4.
- TAG_W, 4: sideband tag width in bits; legal values ≥1.
- KW, $clog2(WIDTH+1): width of trunc_k (derived, not overridable).
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts this cycle.
- a, b  input  WIDTH each  unsigned operands.
- approx_en  input  1  enable truncation mode for this transaction.
- trunc_k  input  KW  number of low columns to drop; values > WIDTH are clamped to WIDTH.
- in_tag  input  TAG_W  opaque tag, returned with the result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the transaction on result.
- out_exact  output  1  1 when result is the exact product.

## Operation
- A transaction is accepted on a cycle with in_valid && in_ready. It is delivered on a cycle with out_valid && out_ready.
- Effective k: k = approx_en ? min(trunc_k, WIDTH) : 0. All mode and tag fields are captured at accept time and travel down the pipe with the data.
- Partial-product bit (i,j) = a[i]&b[j], at weight 2^(i+j). Bits with i+j < k are forced to 0.
- Rounding constant C: C = 2^(k-1) when k>0, a≠0 and b≠0; otherwise C = 0. Consequence: a zero operand always gives result 0.
- result = (sum of surviving partial-product bits) + C. The sum never exceeds the exact product, and adding C cannot overflow 2*WIDTH bits, so no saturation logic is needed.
- out_exact = (k==0). With k==0, result equals a*b exactly.
- Datapath structure: partial-product generation, carry-save (3:2/2:2) reduction, then a final carry-propagate add. Register cut placement across the STAGES stages is implementation-defined; only function and latency are specified.
- Each stage holds a valid bit and its payload. A stage loads when it is empty or when its successor is advancing in the same cycle (bubble-collapsing). The output stage advances on out_ready or when it is empty.
- in_ready = stage 1 is empty OR stage 1 advances this cycle. in_ready therefore depends combinationally on out_ready through the valid chain.
- Transactions are never reordered, dropped or duplicated.

## Timing
- Latency: an accept at edge N gives out_valid=1 after edge N+STAGES, provided no backpressure.
- Throughput: one transaction per cycle while out_ready=1.
- Capacity: STAGES transactions in flight. With out_ready held at 0, exactly STAGES further accepts occur, then in_ready=0.
- Output stability: while out_valid && !out_ready, result, out_tag and out_exact hold stable.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts and delivers in the same cycle.
- Reset (asynchronous, any time, including mid-stream): all valid bits go to 0 and in-flight transactions are discarded.
  - Values during and after reset: out_valid=0, result=0, out_tag=0, out_exact=0.
  - in_ready=1 from the first cycle after reset deasserts.

## Test plan
- Exact mode: WIDTH=8, STAGES=3, a=255, b=255, approx_en=0, tag=5, out_ready=1 → result=65025, out_tag=5, out_exact=1, exactly 3 cycles after accept.
- Approx mode: a=255, b=255, approx_en=1, trunc_k=4 → result=64984 (65025−49+8), out_exact=0. Same operands with trunc_k=9 (clamped to 8) → result=63360 (65025−1793+128).
- Zero operand: a=0, b=19, approx_en=1, trunc_k=4 → result=0 (no rounding constant). Also a=19, b=0, approx_en=0 → result=0, out_exact=1.
- Backpressure: stream tags 0..7 (a=tag+1, b=3) with out_ready=0 for 6 cycles. Required: in_ready drops after 3 accepts, out_valid is held with stable tag 0, and after release tags 0..7 emerge in order, one per cycle, with result=(tag+1)*3.
- Reset mid-stream: assert reset asynchronously with 3 transactions in flight. Required: out_valid=0 and result=0 immediately, none of the 3 transactions ever appears, and a new transaction accepted after reset appears 3 cycles later.
- Randomised sweep: WIDTH ∈ {4,8,16} and STAGES ∈ {1,4}, random a, b, mode, k and out_ready. Every result must match the column-sum reference model and tags must arrive in order.

Source files
------------

// File: rtl/pipelined_approx_multiplier.sv
// Pipelined unsigned WIDTH x WIDTH multiplier: carry-save reduction tree
// with optional low-column truncation plus a rounding constant.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/a/b/approx_en/trunc_k/in_tag : operand side
//   out_valid/out_ready/result/out_tag/out_exact  : product side
module pipelined_approx_multiplier #(
  parameter int WIDTH = 8,
  parameter int STAGES = 3,
  parameter int TAG_W = 4,
  localparam int KW = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  input  logic [KW-1:0]      trunc_k,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_exact
);

  localparam int PW = 2*WIDTH;
  localparam int NR = WIDTH+1;
  localparam int NP = NR+2;
  localparam int L  = STAGES-1;

  typedef struct packed {
    logic [PW-1:0]    s;
    logic [PW-1:0]    c;
    logic [TAG_W-1:0] tag;
    logic             exact;
  } pl_t;

  logic [KW-1:0]     kc;
  logic [KW-1:0]     keff;
  pl_t               pin;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] free;
  pl_t               pl [STAGES];

  assign kc   = (trunc_k > KW'(WIDTH)) ? KW'(WIDTH) : trunc_k;
  assign keff = approx_en ? kc : '0;

  // Rows: WIDTH masked partial products plus one rounding row,
  // compressed level by level with 3:2 / 2:2 counters until two remain.
  always_comb begin : csa
    logic [PW-1:0] rw [NP];
    logic [PW-1:0] nx [NP];
    logic [PW-1:0] mask;
    int n;
    int m;
    mask = '0;
    for (int col = 0; col < PW; col++)
      mask[col] = (col >= int'(keff));
    for (int r = 0; r < NP; r++) begin
      rw[r] = '0;
      nx[r] = '0;
    end
    for (int j = 0; j < WIDTH; j++)
      rw[j] = (PW'(a & {WIDTH{b[j]}}) << j) & mask;
    if (keff != '0 && a != '0 && b != '0)
      rw[WIDTH] = PW'(1) << (keff - KW'(1));
    n = NR;
    for (int lv = 0; lv < NR; lv++) begin
      if (n > 2) begin
        m = 0;
        for (int r = 0; r < NP; r++)
          nx[r] = '0;
        for (int g = 0; 3*g < NR; g++) begin
          if (3*g+2 < n) begin
            nx[m]   = rw[3*g] ^ rw[3*g+1] ^ rw[3*g+2];
            nx[m+1] = ((rw[3*g] & rw[3*g+1]) |
                       (rw[3*g] & rw[3*g+2]) |
                       (rw[3*g+1] & rw[3*g+2])) << 1;
            m = m + 2;
          end else if (3*g+1 < n) begin
            nx[m]   = rw[3*g] ^ rw[3*g+1];
            nx[m+1] = (rw[3*g] & rw[3*g+1]) << 1;
            m = m + 2;
          end else if (3*g < n) begin
            nx[m] = rw[3*g];
            m = m + 1;
          end
        end
        for (int r = 0; r < NP; r++)
          rw[r] = nx[r];
        n = m;
      end
    end
    pin.s     = rw[0];
    pin.c     = rw[1];
    pin.tag   = in_tag;
    pin.exact = (keff == '0);
  end

  // A stage may load when empty or when everything downstream moves.
  always_comb begin : flow
    logic [STAGES-1:0] f;
    f = '0;
    f[L] = !vld[L] || out_ready;
    for (int i = L-1; i >= 0; i--)
      f[i] = !vld[i] || f[i+1];
    free = f;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++)
        pl[i] <= '0;
    end else begin
      if (free[0]) begin
        vld[0] <= in_valid;
        if (in_valid)
          pl[0] <= pin;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (free[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1])
            pl[i] <= pl[i-1];
        end
      end
    end
  end

  // Final carry-propagate add on the registered sum/carry pair.
  assign in_ready  = free[0];
  assign out_valid = vld[L];
  assign result    = pl[L].s + pl[L].c;
  assign out_tag   = pl[L].tag;
  assign out_exact = pl[L].exact;

endmodule
